mcu_el2_dccm_bank_resp: RTL and testbench

- Responder end of the exported DCCM RAM interface: holds the DCCM bank arrays and services the per-bank clock-enable, write-enable, address and data requests from the LSU DCCM wrapper.
- Returns registered read data plus ECC per bank.
- After reset, zero-initialises every bank with a sweep FSM, so the core never reads X or bad ECC.
- Sits on the testbench/SoC side of the memory interface, one instance per MCU core.

---
 rtl/mcu_el2_pkg.sv | 11 +
 rtl/mcu_el2_dccm_bank_ram.sv | 38 +++
 rtl/mcu_el2_dccm_bank_resp.sv | 162 ++++++++++++++++
 tb/tb_mcu_el2_dccm_bank_resp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_el2_pkg.sv
// Shared types and constants for the EL2 DCCM responder: sweep FSM states and
// the default stored-word width (data plus ECC).
package mcu_el2_pkg;

  typedef enum logic [0:0] {DCCM_INIT, DCCM_READY} dccm_resp_state_t;

  localparam int DCCM_DATA_WIDTH_DEF = 32;
  localparam int DCCM_ECC_WIDTH_DEF  = 7;
  localparam int DCCM_RESP_FWIDTH    = DCCM_DATA_WIDTH_DEF + DCCM_ECC_WIDTH_DEF;

endpackage

// File: rtl/mcu_el2_dccm_bank_ram.sv
// One DCCM bank: depth x FWIDTH storage with a single write/read port and a
// registered read output that holds between reads.
module mcu_el2_dccm_bank_ram
  import mcu_el2_pkg::*;
#(
  parameter int INDEX_BITS = 11,
  parameter int FWIDTH     = DCCM_RESP_FWIDTH
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] addr,
  input  logic [FWIDTH-1:0]     wr_data,
  output logic [FWIDTH-1:0]     rd_data
);

  logic [FWIDTH-1:0] mem_q [2**INDEX_BITS];
  logic [FWIDTH-1:0] rd_data_q;

  // Storage is cleared by the top-level sweep, so the array itself has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mcu_el2_dccm_bank_resp.sv
// DCCM responder: per-bank RAMs, post-reset zero sweep, registered read data.
// Optional macro MCU_DCCM_ERR_INJ_EN adds one-shot single/double-bit read error injection.
module mcu_el2_dccm_bank_resp
  import mcu_el2_pkg::*;
#(
  parameter int DCCM_NUM_BANKS  = 8,
  parameter int DCCM_INDEX_BITS = 11,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DCCM_ECC_WIDTH  = 7
) (
  input  logic                                            clk,
  input  logic                                            rst_l,
  input  logic [DCCM_NUM_BANKS-1:0]                       dccm_clken,
  input  logic [DCCM_NUM_BANKS-1:0]                       dccm_wren_bank,
  input  logic [DCCM_NUM_BANKS-1:0][DCCM_INDEX_BITS-1:0]  dccm_addr_bank,
  input  logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0]  dccm_wr_data_bank,
  input  logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]   dccm_wr_ecc_bank,
  output logic [DCCM_NUM_BANKS-1:0][DCCM_DATA_WIDTH-1:0]  dccm_bank_dout,
  output logic [DCCM_NUM_BANKS-1:0][DCCM_ECC_WIDTH-1:0]   dccm_bank_ecc,
  output logic                                            dccm_init_done
`ifdef MCU_DCCM_ERR_INJ_EN
  ,
  input  logic                                            dccm_err_inj_sb,
  input  logic                                            dccm_err_inj_db
`endif
);

  localparam int NB = DCCM_NUM_BANKS;
  localparam int IW = DCCM_INDEX_BITS;
  localparam int DW = DCCM_DATA_WIDTH;
  localparam int FW = DCCM_DATA_WIDTH + DCCM_ECC_WIDTH;
  localparam logic [IW-1:0] CNT_ONE = {{(IW-1){1'b0}}, 1'b1};

  dccm_resp_state_t state_q;
  logic [IW-1:0]    cnt_q;
  logic             done_q;

  logic [NB-1:0]         ram_we;
  logic [NB-1:0]         ram_re;
  logic [NB-1:0][IW-1:0] ram_addr;
  logic [NB-1:0][FW-1:0] ram_wdata;
  logic [NB-1:0][FW-1:0] ram_rdata;

  // Sweep FSM: one index per cycle across all banks, then READY until reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= DCCM_INIT;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        DCCM_INIT: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (&cnt_q) begin
            state_q <= DCCM_READY;
            done_q  <= 1'b1;
          end
        end
        DCCM_READY: begin
          state_q <= DCCM_READY;
        end
        default: begin
          state_q <= DCCM_INIT;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dccm_init_done = done_q;

  // During INIT the sweep owns every bank port and functional requests are dropped.
  always_comb begin
    ram_we    = '0;
    ram_re    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int b = 0; b < NB; b++) begin
      if (state_q == DCCM_READY) begin
        ram_we[b]    = dccm_clken[b] & dccm_wren_bank[b];
        ram_re[b]    = dccm_clken[b] & ~dccm_wren_bank[b];
        ram_addr[b]  = dccm_addr_bank[b];
        ram_wdata[b] = {dccm_wr_ecc_bank[b], dccm_wr_data_bank[b]};
      end else begin
        ram_we[b]    = 1'b1;
        ram_addr[b]  = cnt_q;
      end
    end
  end

  for (genvar g = 0; g < NB; g++) begin : g_bank
    mcu_el2_dccm_bank_ram #(
      .INDEX_BITS (IW),
      .FWIDTH     (FW)
    ) u_ram (
      .clk     (clk),
      .rst_l   (rst_l),
      .wr_en   (ram_we[g]),
      .rd_en   (ram_re[g]),
      .addr    (ram_addr[g]),
      .wr_data (ram_wdata[g]),
      .rd_data (ram_rdata[g])
    );
  end

`ifdef MCU_DCCM_ERR_INJ_EN
  logic                  sb_pend_q, sb_pend_d;
  logic                  db_pend_q, db_pend_d;
  logic [NB-1:0][1:0]    inj_mask_q, inj_mask_d;
  logic                  any_rd;

  // The flip mask is captured with the read and held alongside the read data,
  // so a held output keeps showing the same (possibly corrupted) word.
  always_comb begin
    inj_mask_d = inj_mask_q;
    any_rd     = 1'b0;
    for (int b = 0; b < NB; b++) begin
      if (ram_re[b]) begin
        inj_mask_d[b] = 2'b00;
        if (!any_rd) begin
          if (db_pend_q) begin
            inj_mask_d[b] = 2'b11;
          end else if (sb_pend_q) begin
            inj_mask_d[b] = 2'b01;
          end
          any_rd = 1'b1;
        end
      end
    end
    sb_pend_d = (sb_pend_q & ~any_rd) | dccm_err_inj_sb;
    db_pend_d = (db_pend_q & ~any_rd) | dccm_err_inj_db;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sb_pend_q  <= 1'b0;
      db_pend_q  <= 1'b0;
      inj_mask_q <= '0;
    end else begin
      sb_pend_q  <= sb_pend_d;
      db_pend_q  <= db_pend_d;
      inj_mask_q <= inj_mask_d;
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      dccm_bank_dout[b] = ram_rdata[b][DW-1:0] ^ {{(DW-2){1'b0}}, inj_mask_q[b]};
      dccm_bank_ecc[b]  = ram_rdata[b][FW-1:DW];
    end
  end
`else
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      dccm_bank_dout[b] = ram_rdata[b][DW-1:0];
      dccm_bank_ecc[b]  = ram_rdata[b][FW-1:DW];
    end
  end
`endif

endmodule

// File: tb/tb_mcu_el2_dccm_bank_resp.sv
// Directed bench for mcu_el2_dccm_bank_resp: init sweep timing, read/write,
// bank independence, reset restart and (with MCU_DCCM_ERR_INJ_EN) error injection.
module tb_mcu_el2_dccm_bank_resp;

  localparam int NB = 8;
  localparam int IW = 11;
  localparam int DW = 32;
  localparam int EW = 7;

  logic                  clk;
  logic                  rst_l;
  logic [NB-1:0]         dccm_clken;
  logic [NB-1:0]         dccm_wren_bank;
  logic [NB-1:0][IW-1:0] dccm_addr_bank;
  logic [NB-1:0][DW-1:0] dccm_wr_data_bank;
  logic [NB-1:0][EW-1:0] dccm_wr_ecc_bank;
  logic [NB-1:0][DW-1:0] dccm_bank_dout;
  logic [NB-1:0][EW-1:0] dccm_bank_ecc;
  logic                  dccm_init_done;
`ifdef MCU_DCCM_ERR_INJ_EN
  logic                  dccm_err_inj_sb;
  logic                  dccm_err_inj_db;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  mcu_el2_dccm_bank_resp #(
    .DCCM_NUM_BANKS  (NB),
    .DCCM_INDEX_BITS (IW),
    .DCCM_DATA_WIDTH (DW),
    .DCCM_ECC_WIDTH  (EW)
  ) dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .dccm_clken        (dccm_clken),
    .dccm_wren_bank    (dccm_wren_bank),
    .dccm_addr_bank    (dccm_addr_bank),
    .dccm_wr_data_bank (dccm_wr_data_bank),
    .dccm_wr_ecc_bank  (dccm_wr_ecc_bank),
    .dccm_bank_dout    (dccm_bank_dout),
    .dccm_bank_ecc     (dccm_bank_ecc),
    .dccm_init_done    (dccm_init_done)
`ifdef MCU_DCCM_ERR_INJ_EN
    ,
    .dccm_err_inj_sb   (dccm_err_inj_sb),
    .dccm_err_inj_db   (dccm_err_inj_db)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dccm_clken        = '0;
    dccm_wren_bank    = '0;
    dccm_addr_bank    = '0;
    dccm_wr_data_bank = '0;
    dccm_wr_ecc_bank  = '0;
  endtask

  task automatic req(input int b, input logic wr, input logic [IW-1:0] a,
                     input logic [DW-1:0] d, input logic [EW-1:0] e);
    dccm_clken[b]        = 1'b1;
    dccm_wren_bank[b]    = wr;
    dccm_addr_bank[b]    = a;
    dccm_wr_data_bank[b] = d;
    dccm_wr_ecc_bank[b]  = e;
  endtask

  // Runs the full sweep after a reset release; done must rise exactly at edge 2048.
  task automatic run_init(input string tag);
    for (int i = 1; i <= 2048; i++) begin
      tick();
      if (i == 1)    chk({tag, "_done_c1"},    64'(dccm_init_done), 64'd0);
      if (i == 2047) chk({tag, "_done_c2047"}, 64'(dccm_init_done), 64'd0);
      if (i == 2048) chk({tag, "_done_c2048"}, 64'(dccm_init_done), 64'd1);
    end
  endtask

  initial begin
    rst_l = 1'b0;
    idle();
`ifdef MCU_DCCM_ERR_INJ_EN
    dccm_err_inj_sb = 1'b0;
    dccm_err_inj_db = 1'b0;
`endif
    tick();
    tick();
    chk("rst_dout0", 64'(dccm_bank_dout[0]), 64'd0);
    chk("rst_ecc0",  64'(dccm_bank_ecc[0]),  64'd0);
    chk("rst_done",  64'(dccm_init_done),    64'd0);

    // First sweep, with a functional write then read of bank 3 idx 5 that must be ignored.
    rst_l = 1'b1;
    req(3, 1'b1, 11'd5, 32'hCAFEF00D, 7'h33);
    for (int i = 1; i <= 2048; i++) begin
      tick();
      if (i == 1) req(3, 1'b0, 11'd5, 32'h0, 7'h0);
      if (i == 2) begin
        chk("init_rd_b3_dout", 64'(dccm_bank_dout[3]), 64'd0);
        chk("init_rd_b3_ecc",  64'(dccm_bank_ecc[3]),  64'd0);
        idle();
      end
      if (i == 1)    chk("init_done_c1",    64'(dccm_init_done), 64'd0);
      if (i == 2047) chk("init_done_c2047", 64'(dccm_init_done), 64'd0);
      if (i == 2048) chk("init_done_c2048", 64'(dccm_init_done), 64'd1);
    end

    // Write then read-back in the next cycle.
    req(2, 1'b1, 11'h010, 32'hDEADBEEF, 7'h5A);
    tick();
    chk("wr_b2_hold", 64'(dccm_bank_dout[2]), 64'd0);
    idle();
    req(2, 1'b0, 11'h010, 32'h0, 7'h0);
    tick();
    chk("rd_b2_dout", 64'(dccm_bank_dout[2]), 64'hDEADBEEF);
    chk("rd_b2_ecc",  64'(dccm_bank_ecc[2]),  64'h5A);

    // Bank 7: written word then unwritten top index; bank 3 idx 5 never written.
    idle();
    req(7, 1'b1, 11'h7FE, 32'h12345678, 7'h11);
    tick();
    idle();
    req(7, 1'b0, 11'h7FE, 32'h0, 7'h0);
    tick();
    chk("rd_b7_7fe", 64'(dccm_bank_dout[7]), 64'h12345678);
    idle();
    req(7, 1'b0, 11'h7FF, 32'h0, 7'h0);
    req(3, 1'b0, 11'd5,   32'h0, 7'h0);
    tick();
    chk("rd_b7_7ff_dout", 64'(dccm_bank_dout[7]), 64'd0);
    chk("rd_b7_7ff_ecc",  64'(dccm_bank_ecc[7]),  64'd0);
    chk("rd_b3_idx5",     64'(dccm_bank_dout[3]), 64'd0);

    // Parallel, independent bank traffic.
    idle();
    req(0, 1'b1, 11'd2, 32'hA5A5A5A5, 7'h0F);
    req(1, 1'b1, 11'd3, 32'h33333333, 7'h03);
    tick();
    idle();
    req(0, 1'b0, 11'd2, 32'h0, 7'h0);
    req(1, 1'b0, 11'd3, 32'h0, 7'h0);
    tick();
    chk("par_rd_b0", 64'(dccm_bank_dout[0]), 64'hA5A5A5A5);
    chk("par_rd_b1", 64'(dccm_bank_dout[1]), 64'h33333333);
    idle();
    req(0, 1'b1, 11'd1, 32'h11111111, 7'h22);
    req(1, 1'b0, 11'd1, 32'h0, 7'h0);
    tick();
    chk("par_b1_rd0",  64'(dccm_bank_dout[1]), 64'd0);
    chk("par_b0_hold", 64'(dccm_bank_dout[0]), 64'hA5A5A5A5);
    // Write enables without clken must do nothing.
    idle();
    dccm_wren_bank       = '1;
    dccm_addr_bank[2]    = 11'h010;
    dccm_wr_data_bank[2] = 32'hFFFFFFFF;
    tick();
    chk("noclk_b0_hold", 64'(dccm_bank_dout[0]), 64'hA5A5A5A5);
    chk("noclk_b2_hold", 64'(dccm_bank_dout[2]), 64'hDEADBEEF);
    idle();
    req(0, 1'b0, 11'd1,   32'h0, 7'h0);
    req(2, 1'b0, 11'h010, 32'h0, 7'h0);
    tick();
    chk("rd_b0_idx1_dout", 64'(dccm_bank_dout[0]), 64'h11111111);
    chk("rd_b0_idx1_ecc",  64'(dccm_bank_ecc[0]),  64'h22);
    chk("rd_b2_after_ign", 64'(dccm_bank_dout[2]), 64'hDEADBEEF);
    idle();

`ifdef MCU_DCCM_ERR_INJ_EN
    dccm_err_inj_sb = 1'b1;
    tick();
    dccm_err_inj_sb = 1'b0;
    req(2, 1'b0, 11'h010, 32'h0, 7'h0);
    tick();
    chk("inj_sb_rd",     64'(dccm_bank_dout[2]), 64'hDEADBEEE);
    chk("inj_sb_ecc",    64'(dccm_bank_ecc[2]),  64'h5A);
    tick();
    chk("inj_sb_oneshot", 64'(dccm_bank_dout[2]), 64'hDEADBEEF);
    idle();
    dccm_err_inj_db = 1'b1;
    tick();
    dccm_err_inj_db = 1'b0;
    req(2, 1'b0, 11'h010, 32'h0, 7'h0);
    tick();
    chk("inj_db_rd", 64'(dccm_bank_dout[2]), 64'hDEADBEEC);
    tick();
    chk("inj_db_oneshot", 64'(dccm_bank_dout[2]), 64'hDEADBEEF);
    idle();
`endif

    // Reset while READY: outputs clear asynchronously and the sweep reruns.
    rst_l = 1'b0;
    #1;
    chk("rdy_rst_dout2", 64'(dccm_bank_dout[2]), 64'd0);
    chk("rdy_rst_done",  64'(dccm_init_done),    64'd0);
    tick();
    rst_l = 1'b1;
    for (int i = 1; i <= 1000; i++) tick();
    chk("midinit_done", 64'(dccm_init_done), 64'd0);
    rst_l = 1'b0;
    tick();
    tick();
    rst_l = 1'b1;
    run_init("reinit");

    req(2, 1'b0, 11'h010, 32'h0, 7'h0);
    req(0, 1'b0, 11'd1,   32'h0, 7'h0);
    tick();
    chk("post_rst_b2_dout", 64'(dccm_bank_dout[2]), 64'd0);
    chk("post_rst_b2_ecc",  64'(dccm_bank_ecc[2]),  64'd0);
    chk("post_rst_b0_dout", 64'(dccm_bank_dout[0]), 64'd0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
